// File: rtl/alu_arbiter_seq_if.sv
// alu_arbiter_seq_if: bundles the two request channels, the ALU drive/return
// signals and the response channel of alu_arbiter_seq.
// slave  : the arbiter/sequencer side.
// master : the environment (requesters, ALU, response consumer).
interface alu_arbiter_seq_if;
    // request channels
    logic        req0_valid;
    logic        req0_ready;
    logic [27:0] req0_ctrl;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [27:0] req1_ctrl;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    // registered ALU drive
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        alu_sbit;
    logic [3:0]  alu_cond;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_srcontrol;
    logic [15:0] alu_imvalue;
    logic [3:0]  alu_inflags;

    // ALU return
    logic [31:0] alu_result;
    logic [3:0]  alu_outflags;

    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    logic        busy;

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_in1, alu_in2, alu_sbit, alu_cond, alu_opcode,
        output alu_srcontrol, alu_imvalue, alu_inflags,
        input  alu_result, alu_outflags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_in1, alu_in2, alu_sbit, alu_cond, alu_opcode,
        input  alu_srcontrol, alu_imvalue, alu_inflags,
        output alu_result, alu_outflags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one single-cycle ALU between two requesters.
// Grants one request in IDLE, holds the latched operands/control on the ALU
// for a per-opcode execute time (MUL_CYCLES for multiply, else 1), captures
// result/flags into a response that is held until accepted, and owns the
// NZCV flags register feeding the ALU.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration;
// otherwise req0 has fixed priority.
module alu_arbiter_seq #(
    parameter int unsigned MUL_CYCLES = 3,          // 1..15
    parameter logic [3:0]  FLAGS_INIT = 4'b0000     // {N,Z,C,V}
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic        sbit;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic [2:0]  srcontrol;
        logic [15:0] imvalue;
    } ctrl_t;

    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] MUL_LEN = 4'(MUL_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    ctrl_t       ctrl_q;
    logic [31:0] in1_q;
    logic [31:0] in2_q;
    logic [3:0]  flags_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;

    logic        grant_any;
    logic        grant1;
    ctrl_t       sel_ctrl;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

`ifdef ALU_ARB_RR_EN
    // 1 = req1 was granted last, so req0 wins the next tie (req0 first after reset)
    logic last_grant;

    // Round-robin pick: req1 wins a tie only if req0 was granted last
    always_comb begin
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end

    // Pointer follows every grant
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant_any)
            last_grant <= grant1;
    end
`else
    // Fixed priority: req1 only when req0 is idle
    always_comb begin
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`endif

    // Grant qualification and selected-request mux; reset suppresses any ready
    always_comb begin
        grant_any = (state == IDLE) & ~reset & (bus.req0_valid | bus.req1_valid);
        sel_ctrl  = grant1 ? ctrl_t'(bus.req1_ctrl) : ctrl_t'(bus.req0_ctrl);
        sel_a     = grant1 ? bus.req1_a : bus.req0_a;
        sel_b     = grant1 ? bus.req1_b : bus.req0_b;
    end

    assign bus.req0_ready = grant_any & ~grant1;
    assign bus.req1_ready = grant_any &  grant1;

    // Sequencer FSM: accept, hold operands for the execute time, capture, respond
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ctrl_q       <= '0;
            in1_q        <= 32'd0;
            in2_q        <= 32'd0;
            flags_q      <= FLAGS_INIT;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ctrl_q   <= sel_ctrl;
                        in1_q    <= sel_a;
                        in2_q    <= sel_b;
                        rsp_id_q <= grant1;
                        cnt      <= (sel_ctrl.opcode == OP_MUL) ? MUL_LEN : 4'd1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs stay put; sample its output in the last execute cycle
                    if (cnt == 4'd1) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_flags_q  <= bus.alu_outflags;
                        if (ctrl_q.sbit)
                            flags_q <= bus.alu_outflags;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_in1       = in1_q;
    assign bus.alu_in2       = in2_q;
    assign bus.alu_sbit      = ctrl_q.sbit;
    assign bus.alu_cond      = ctrl_q.cond;
    assign bus.alu_opcode    = ctrl_q.opcode;
    assign bus.alu_srcontrol = ctrl_q.srcontrol;
    assign bus.alu_imvalue   = ctrl_q.imvalue;
    assign bus.alu_inflags   = flags_q;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: directed checks of alu_arbiter_seq with a small ALU
// stand-in (0000 add, 0001 sub, 0010 mul; flags N,Z from the result).
module tb_alu_arbiter_seq;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_arbiter_seq_if bus ();

    alu_arbiter_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in driven from the registered ALU inputs
    always_comb begin
        logic [31:0] res;
        case (bus.alu_opcode)
            4'b0000: res = bus.alu_in1 + bus.alu_in2;
            4'b0001: res = bus.alu_in1 - bus.alu_in2;
            4'b0010: res = bus.alu_in1 * bus.alu_in2;
            default: res = bus.alu_in1;
        endcase
        bus.alu_result   = res;
        bus.alu_outflags = {res[31], (res == 32'd0), 2'b00};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] mk(input logic sbit, input logic [3:0] op, input logic [15:0] imm);
        return {sbit, 4'b0000, op, 3'b000, imm};
    endfunction

    task automatic drive(input int p, input logic [27:0] c, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Accept response in the current RESP cycle and return to IDLE
    task automatic finish_rsp;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("idle_after_rsp", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int got [4];
        int ng;
        int exp_id;

        bus.req0_valid = 1'b0; bus.req0_ctrl = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ctrl = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;

        // Reset with a pending request: no ready, all outputs at reset values
        reset = 1'b1;
        drive(0, mk(1'b1, 4'b0000, 16'h0), 32'd1, 32'd1);
        tick();
        tick();
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_alu_in1", bus.alu_in1, 32'd0);
        chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        chk("rst_inflags", 32'(bus.alu_inflags), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single add on req0: 5+7
        drive(0, mk(1'b1, 4'b0000, 16'h00A5), 32'd5, 32'd7);
        #1;
        chk("add_ready0", 32'(bus.req0_ready), 32'd1);
        chk("add_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        chk("add_busy", 32'(bus.busy), 32'd1);
        chk("add_rsp_early", 32'(bus.rsp_valid), 32'd0);
        chk("add_in1", bus.alu_in1, 32'd5);
        chk("add_in2", bus.alu_in2, 32'd7);
        chk("add_sbit", 32'(bus.alu_sbit), 32'd1);
        chk("add_imm", 32'(bus.alu_imvalue), 32'h00A5);
        tick();
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_result", bus.rsp_result, 32'd12);
        chk("add_id", 32'(bus.rsp_id), 32'd0);
        chk("add_flags", 32'(bus.rsp_flags), 32'd0);
        chk("add_inflags", 32'(bus.alu_inflags), 32'd0);
        finish_rsp();

        // Multiply 6*7: operands held T+1..T+3, response at T+4
        drive(0, mk(1'b0, 4'b0010, 16'h0), 32'd6, 32'd7);
        #1;
        chk("mul_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("mul_hold_in1", bus.alu_in1, 32'd6);
            chk("mul_hold_in2", bus.alu_in2, 32'd7);
            chk("mul_hold_op", 32'(bus.alu_opcode), 32'd2);
            chk("mul_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("mul_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("mul_result", bus.rsp_result, 32'd42);
        finish_rsp();

        // Subtract 3-3, sbit 0: reports Z but flags register untouched
        drive(0, mk(1'b0, 4'b0001, 16'h0), 32'd3, 32'd3);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("sub0_flags", 32'(bus.rsp_flags), 32'h4);
        chk("sub0_inflags", 32'(bus.alu_inflags), 32'd0);
        finish_rsp();

        // Subtract 3-3, sbit 1: flags register takes 0100 at T+2
        drive(0, mk(1'b1, 4'b0001, 16'h0), 32'd3, 32'd3);
        tick();
        bus.req0_valid = 1'b0;
        chk("sub1_inflags_t1", 32'(bus.alu_inflags), 32'd0);
        tick();
        chk("sub1_flags", 32'(bus.rsp_flags), 32'h4);
        chk("sub1_inflags_t2", 32'(bus.alu_inflags), 32'h4);
        finish_rsp();

        // Reset in the middle of a multiply
        drive(0, mk(1'b1, 4'b0010, 16'h0), 32'd6, 32'd7);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        reset = 1'b1;
        drive(0, mk(1'b0, 4'b0000, 16'h0), 32'd5, 32'd7);
        drive(1, mk(1'b0, 4'b0000, 16'h0), 32'd9, 32'd9);
        tick();
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_inflags", 32'(bus.alu_inflags), 32'd0);
        chk("mrst_ready0_in_rst", 32'(bus.req0_ready), 32'd0);
        chk("mrst_ready1_in_rst", 32'(bus.req1_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("mrst_first_ready0", 32'(bus.req0_ready), 32'd1);
        chk("mrst_first_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("mrst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("mrst_result", bus.rsp_result, 32'd12);
        finish_rsp();

        // Contention from a fresh reset with both requesters always valid
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, mk(1'b0, 4'b0000, 16'h0), 32'd1, 32'd2);
        drive(1, mk(1'b0, 4'b0000, 16'h0), 32'd3, 32'd4);
        bus.rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (bus.req0_ready || bus.req1_ready) begin
                chk("cont_excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
                got[ng] = bus.req1_ready ? 1 : 0;
                ng++;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("cont_ngrants", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            chk($sformatf("cont_order%0d", i), 32'(got[i]), 32'(exp_id));
        end
        for (int i = 0; i < 4; i++) tick();
        bus.rsp_ready = 1'b0;
        chk("cont_drained", 32'(bus.busy), 32'd0);

        // Backpressure: response held 5 cycles while req1 waits
        drive(0, mk(1'b0, 4'b0000, 16'h0), 32'd5, 32'd7);
        #1;
        chk("bp_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        drive(1, mk(1'b0, 4'b0000, 16'h0), 32'd100, 32'd1);
        #1;
        chk("bp_exec_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_result", bus.rsp_result, 32'd12);
            chk("bp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_ready1_acc_cycle", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        chk("bp_ready1_grant", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("bp_r1_result", bus.rsp_result, 32'd101);
        chk("bp_r1_id", 32'(bus.rsp_id), 32'd1);
        finish_rsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter_seq.md
# alu_arbiter_seq

Shares the single-cycle ALU between two requesters (fetch/decode issue port and a debug/test port) and sequences each operation through it. Arbitrates, latches operands and control into registers that drive the ALU, holds them stable for a fixed per-opcode execution time, captures result and flags, and returns them on a response channel. Owns the architectural NZCV flags register that feeds the ALU's `inflags`.

## Interface
- `MUL_CYCLES`, default 3: execute cycles held for opcode `4'b0010` (multiply); legal range 1..15.
- `FLAGS_INIT`, default `4'b0000`: reset value of the flags register, ordered {N,Z,C,V}.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: requester has an operation pending.
- `req0_ready` / `req1_ready` out 1: acceptance pulse; handshake completes when valid and ready are both high.
- `req0_ctrl` / `req1_ctrl` in 28: {sbit[27], cond[26:23], opcode[22:19], srcontrol[18:16], imvalue[15:0]}.
- `req0_a` / `req1_a` in 32: operand routed to ALU `in1`.
- `req0_b` / `req1_b` in 32: operand routed to ALU `in2`.
- `alu_in1`, `alu_in2` out 32: registered ALU operands.
- `alu_sbit` out 1, `alu_cond` out 4, `alu_opcode` out 4, `alu_srcontrol` out 3, `alu_imvalue` out 16: registered ALU control.
- `alu_inflags` out 4: flags register contents.
- `alu_result` in 32, `alu_outflags` in 4: ALU outputs.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_result` out 32, `rsp_flags` out 4: captured ALU outputs.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - **IDLE:**
    - If any `reqN_valid` is high, grant one requester and assert its `reqN_ready` combinationally this cycle.
    - Latch its ctrl and operands into the `alu_*` registers.
    - Record `rsp_id` and load the execute counter: `MUL_CYCLES` for opcode `0010`, else 1.
    - Go to EXEC.
  - **EXEC:**
    - `alu_*` outputs are held constant.
    - Counter decrements each cycle.
    - In the cycle the counter equals 1: capture `alu_result` into `rsp_result` and `alu_outflags` into `rsp_flags`.
    - If the latched sbit is 1, also write `alu_outflags` into the flags register.
    - Go to RESP.
  - **RESP:**
    - `rsp_valid` is high and the response payload is stable.
    - On `rsp_ready` high, go to IDLE.
    - No new request is accepted in RESP, including the cycle of `rsp_ready`.
- `reqN_ready` is never high outside IDLE and never high for both requesters together.
- Flags are updated only by captured operations with sbit=1. Operations with sbit=0, including compare (`1000`), leave the flags untouched. Condition-failed operations become NOP inside the ALU; the flags register still takes `alu_outflags` if sbit=1.
- The opcode is passed through unchanged; `1111` and undefined opcodes use the 1-cycle execute time.
- `rsp_flags` always reports `alu_outflags` at capture, regardless of sbit.

## Timing
- Accept at cycle T (IDLE).
- EXEC occupies T+1 .. T+L, where L = `MUL_CYCLES` for multiply, else 1.
- `rsp_valid` rises at T+L+1.
- Earliest next accept is the cycle after `rsp_ready` is sampled high. Minimum occupancy is L+2 cycles per operation.
- The flags register takes its new value at T+L+1, visible on `alu_inflags` from that cycle.
- Reset values:
  - state IDLE; all `alu_*` data/control outputs 0; `alu_inflags` = `FLAGS_INIT`.
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags`, `busy`, `reqN_ready` all 0.
  - last-grant pointer = 1, so req0 wins first.
- Reset asserted mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and the flags register is restored to `FLAGS_INIT`.
- Reset dominates `reqN_valid`: no ready is asserted during a reset cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - With both requesters valid in IDLE, grant the one not granted last.
  - With a single requester valid, grant it.
  - The pointer updates on every grant.
- `ALU_ARB_RR_EN` undefined: fixed priority. req0 always wins when valid, and the pointer logic is absent.

## Test plan
- Single add, req0: ctrl opcode `0000`, sbit 1, cond `0000`; a=5, b=7; ALU returns 12, flags `0000`. Required: `req0_ready` at T, `rsp_valid` at T+2, `rsp_result`=12, `rsp_id`=0, `alu_inflags`=`0000`.
- Multiply latency with `MUL_CYCLES`=3: opcode `0010`, a=6, b=7. Required: `alu_*` stable T+1..T+3, `rsp_valid` at T+4, `rsp_result`=42.
- sbit gating: subtract 3−3 with sbit 0 returning flags `0100`. Required: `rsp_flags`=`0100`, `alu_inflags` unchanged. Repeat with sbit 1: `alu_inflags`=`0100` from T+2.
- Contention, RR enabled: both valid continuously. Required: grant order 0,1,0,1 across four operations. Without `ALU_ARB_RR_EN`: 0,0,0,0.
- Backpressure: hold `rsp_ready` low 5 cycles in RESP with req1 valid. Required: `rsp_valid` and payload stable, `req1_ready` low throughout, req1 granted the cycle after `rsp_ready` is sampled high.
- Reset mid-multiply: assert reset at T+2. Required: next cycle state IDLE, `rsp_valid` 0, `busy` 0, `alu_inflags`=`FLAGS_INIT`, req0 granted first afterwards.
